// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: ALU select codes, sequencer state encoding and the opcode legality check
// shared by alu_ctrl.
package alu_ctrl_pkg;

   localparam logic [3:0] SEL_CLR   = 4'b0000;
   localparam logic [3:0] SEL_ADD   = 4'b0001;
   localparam logic [3:0] SEL_SUB   = 4'b0010;
   localparam logic [3:0] SEL_NOR   = 4'b0011;
   localparam logic [3:0] SEL_SHR   = 4'b0100;
   localparam logic [3:0] SEL_SHL   = 4'b0101;
   localparam logic [3:0] SEL_PASSA = 4'b0110;
   localparam logic [3:0] SEL_LDB   = 4'b0111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      legal = 1'b0;
      unique case (op)
         SEL_CLR, SEL_ADD, SEL_SUB, SEL_NOR,
         SEL_SHR, SEL_SHL, SEL_PASSA, SEL_LDB: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_ctrl.sv
// alu_ctrl: valid/ready command sequencer for an external combinational ALU (A = acc, B = operand).
// Build option ALU_CTRL_REPEAT_EN: one command executes cmd_rep+1 times before responding.
module alu_ctrl #(
   parameter int unsigned DW   = 8,
   parameter int unsigned REPW = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [3:0]      cmd_op,
   input  logic [DW-1:0]   cmd_data,
   input  logic [REPW-1:0] cmd_rep,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [3:0]      SelALU,
   input  logic [DW-1:0]   alu_result,
   input  logic            alu_cout,
   input  logic            alu_zout,
   output logic [DW-1:0]   acc,
   output logic            flag_c,
   output logic            flag_z,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_err
);
   import alu_ctrl_pkg::*;

   state_e          state_q, state_d;
   logic [3:0]      sel_q, sel_d;
   logic [DW-1:0]   acc_q, acc_d;
   logic [DW-1:0]   b_q, b_d;
   logic            fc_q, fc_d;
   logic            fz_q, fz_d;
   logic            err_q, err_d;

`ifdef ALU_CTRL_REPEAT_EN
   logic [REPW-1:0] rep_q, rep_d;
   logic            first_q, first_d;
`else
   logic            unused_rep;
   assign unused_rep = ^cmd_rep;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= SEL_CLR;
         acc_q   <= '0;
         b_q     <= '0;
         fc_q    <= 1'b0;
         fz_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef ALU_CTRL_REPEAT_EN
         rep_q   <= '0;
         first_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         fc_q    <= fc_d;
         fz_q    <= fz_d;
         err_q   <= err_d;
`ifdef ALU_CTRL_REPEAT_EN
         rep_q   <= rep_d;
         first_q <= first_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      acc_d     = acc_q;
      b_d       = b_q;
      fc_d      = fc_q;
      fz_d      = fz_q;
      err_d     = err_q;
`ifdef ALU_CTRL_REPEAT_EN
      rep_d     = rep_q;
      first_d   = first_q;
`endif
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      SelALU    = SEL_CLR;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               sel_d = cmd_op;
               b_d   = cmd_data;
               err_d = ~is_legal_op(cmd_op);
               // Illegal ops skip ISSUE entirely so acc and flags are left untouched.
               state_d = is_legal_op(cmd_op) ? ISSUE : RESP;
`ifdef ALU_CTRL_REPEAT_EN
               rep_d   = cmd_rep;
               first_d = 1'b1;
`endif
            end
         end

         ISSUE: begin
            SelALU = sel_q;
            acc_d  = alu_result;
            fz_d   = alu_zout;
`ifdef ALU_CTRL_REPEAT_EN
            // Carry is sticky across iterations; the first iteration discards the previous command's carry.
            fc_d    = alu_cout | (fc_q & ~first_q);
            first_d = 1'b0;
            if (rep_q != '0) begin
               rep_d = rep_q - REPW'(1);
            end else begin
               state_d = RESP;
            end
`else
            fc_d    = alu_cout;
            state_d = RESP;
`endif
         end

         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign alu_a   = acc_q;
   assign alu_b   = b_q;
   assign acc     = acc_q;
   assign flag_c  = fc_q;
   assign flag_z  = fz_q;
   assign rsp_err = err_q;

   a_sel_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != ISSUE) |-> (SelALU == SEL_CLR));

   a_ready_vs_rsp: assert property (@(posedge clk) disable iff (!rst_n)
      !(cmd_ready && rsp_valid));

   a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(acc_q) && $stable(fc_q) && $stable(fz_q)));

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: alu_ctrl next to a combinational 8-bit ALU, checked every cycle against a
// transaction-level reference model; honours ALU_CTRL_REPEAT_EN.
module tb_alu_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_data;
   logic [3:0] cmd_rep;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [3:0] SelALU;
   logic [7:0] alu_result;
   logic       alu_cout;
   logic       alu_zout;
   logic [7:0] acc;
   logic       flag_c;
   logic       flag_z;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_err;

   int unsigned total;
   int unsigned bad;

`ifdef ALU_CTRL_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   alu_ctrl #(.DW(8), .REPW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_data(cmd_data), .cmd_rep(cmd_rep),
      .alu_a(alu_a), .alu_b(alu_b), .SelALU(SelALU),
      .alu_result(alu_result), .alu_cout(alu_cout), .alu_zout(alu_zout),
      .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU behaviour: returns {cout, zout, result}
   function automatic logic [9:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      logic [7:0] r;
      logic       c;
      w = '0;
      r = '0;
      c = 1'b0;
      case (s)
         4'd1: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
         4'd2: begin r = a - b; c = (a < b); end
         4'd3: r = ~(a | b);
         4'd4: begin r = a >> 1; c = a[0]; end
         4'd5: begin r = a << 1; c = a[7]; end
         4'd6: r = a;
         4'd7: r = b;
         default: r = '0;
      endcase
      return {c, (r == 8'h00), r};
   endfunction

   logic [9:0] alu_o;
   assign alu_o      = alu_f(SelALU, alu_a, alu_b);
   assign alu_result = alu_o[7:0];
   assign alu_zout   = alu_o[8];
   assign alu_cout   = alu_o[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a command occupies m_issue ALU cycles, then a response waits for rsp_ready.
   logic [7:0]  m_acc, m_b;
   logic [3:0]  m_op;
   logic        m_c, m_z, m_err, m_resp, m_first;
   int unsigned m_issue;
   logic [9:0]  m_next;
   assign m_next = alu_f(m_op, m_acc, m_b);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_acc <= '0; m_b <= '0; m_op <= '0;
         m_c <= 1'b0; m_z <= 1'b0; m_err <= 1'b0; m_resp <= 1'b0; m_first <= 1'b0;
         m_issue <= 0;
      end else if (m_issue != 0) begin
         m_acc   <= m_next[7:0];
         m_z     <= m_next[8];
         m_c     <= m_next[9] | (m_c & ~m_first);
         m_first <= 1'b0;
         m_issue <= m_issue - 1;
         if (m_issue == 1) m_resp <= 1'b1;
      end else if (m_resp) begin
         if (rsp_ready) m_resp <= 1'b0;
      end else if (cmd_valid) begin
         m_op <= cmd_op;
         m_b  <= cmd_data;
         if (cmd_op > 4'd7) begin
            m_err  <= 1'b1;
            m_resp <= 1'b1;
         end else begin
            m_err   <= 1'b0;
            m_first <= 1'b1;
            m_issue <= REP_EN ? int'(cmd_rep) + 1 : 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(m_issue == 0 && !m_resp));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
         chk("SelALU", 32'(SelALU), 32'((m_issue != 0) ? m_op : 4'd0));
         chk("acc", 32'(acc), 32'(m_acc));
         chk("alu_a", 32'(alu_a), 32'(m_acc));
         chk("alu_b", 32'(alu_b), 32'(m_b));
         chk("flag_c", 32'(flag_c), 32'(m_c));
         chk("flag_z", 32'(flag_z), 32'(m_z));
         if (m_resp) chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
   end

   task automatic send(input logic [3:0] op, input logic [7:0] d, input logic [3:0] rep,
                       input int unsigned hold, input bit early, input bit poke,
                       output int unsigned lat, output logic err);
      int unsigned n;
      n = 0;
      while (!cmd_ready && n < 64) begin @(negedge clk); n++; end
      chk("accept_wait", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_rep = rep; rsp_ready = early;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_data = 8'($urandom); cmd_rep = 4'($urandom);
      lat = 0;
      while (!rsp_valid && lat < 64) begin @(negedge clk); lat++; end
      chk("rsp_wait", 32'(rsp_valid), 32'd1);
      err = rsp_err;
      if (!early) begin
         for (int unsigned i = 0; i < hold; i++) begin
            if (poke) begin cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_data = 8'($urandom); end
            @(negedge clk);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   int unsigned lat;
   logic        err;
   logic [3:0]  rop;
   logic [3:0]  rrep;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_rep = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_acc", 32'(acc), 32'h0);
      chk("rst_alu_b", 32'(alu_b), 32'h0);
      chk("rst_flags", 32'({flag_c, flag_z}), 32'h0);
      chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
      chk("rst_sel", 32'(SelALU), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(cmd_ready), 32'd1);

      send(4'd1, 8'h05, 4'd0, 0, 1'b0, 1'b0, lat, err);
      chk("t1_acc", 32'(acc), 32'h05);
      chk("t1_flags", 32'({flag_c, flag_z}), 32'h0);
      chk("t1_lat", lat, 32'd1);
      chk("t1_model", 32'(m_acc), 32'h05);

      send(4'd2, 8'h05, 4'd0, 0, 1'b0, 1'b0, lat, err);
      chk("t2_acc", 32'(acc), 32'h00);
      chk("t2_flags", 32'({flag_c, flag_z}), 32'h1);

      send(4'd7, 8'h02, 4'd0, 0, 1'b0, 1'b0, lat, err);
      send(4'd1, 8'hFF, 4'd0, 0, 1'b0, 1'b0, lat, err);
      chk("t3_acc", 32'(acc), 32'h01);
      chk("t3_flags", 32'({flag_c, flag_z}), 32'h2);
      chk("t3_model", 32'({m_c, m_acc}), 32'h101);

      send(4'd1, 8'h10, 4'd0, 3, 1'b0, 1'b1, lat, err);
      chk("t4_acc", 32'(acc), 32'h11);

      send(4'd7, 8'h33, 4'd0, 0, 1'b0, 1'b0, lat, err);
      send(4'd9, 8'hAA, 4'd0, 1, 1'b0, 1'b0, lat, err);
      chk("t5_err", 32'(err), 32'd1);
      chk("t5_lat", lat, 32'd0);
      chk("t5_acc", 32'(acc), 32'h33);
      send(4'd6, 8'h00, 4'd0, 0, 1'b1, 1'b0, lat, err);
      chk("t5_err_clr", 32'(err), 32'd0);

      cmd_valid = 1'b1; cmd_op = 4'd1; cmd_data = 8'h01; cmd_rep = 4'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("t6_issue_sel", 32'(SelALU), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("t6_acc", 32'(acc), 32'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);

`ifdef ALU_CTRL_REPEAT_EN
      send(4'd7, 8'h03, 4'd0, 0, 1'b0, 1'b0, lat, err);
      send(4'd5, 8'h00, 4'd2, 0, 1'b0, 1'b0, lat, err);
      chk("t7_acc", 32'(acc), 32'h18);
      chk("t7_lat", lat, 32'd3);
      chk("t7_flags", 32'({flag_c, flag_z}), 32'h0);
`endif

      for (int unsigned k = 0; k < 300; k++) begin
         rop = 4'($urandom_range(0, 9));
         if (rop > 4'd7) rop = 4'($urandom_range(8, 15));
         rrep = 4'($urandom_range(0, 3));
         send(rop, 8'($urandom), rrep, $urandom_range(0, 2),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), lat, err);
         chk("rnd_err", 32'(err), 32'(rop > 4'd7));
         chk("rnd_lat", lat, (rop > 4'd7) ? 32'd0 : (REP_EN ? 32'(rrep) + 32'd1 : 32'd1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
